// File: rtl/lane_merge_pkg.sv
`default_nettype none
// ============================================================================
//  Module : lane_merge_pkg
//  Brief  : Shared constants and priority-rotation helper for lane_merge_reg.
//  Rev    : 1.0
// ============================================================================
package lane_merge_pkg;

    localparam int LM_MODE_FIXED = 0;
    localparam int LM_MODE_RR    = 1;

    // Port index visited at step k of a priority scan that begins at 'start'.
    function automatic int lm_rot_port(input int start, input int k, input int nports);
        return (start + k) % nports;
    endfunction

endpackage
`default_nettype wire

// File: rtl/lane_merge_arb.sv
`default_nettype none
// ============================================================================
//  Module : lane_merge_arb
//  Brief  : Combinational per-bit resolver: picks one writer per bit, flags overlaps.
//  Rev    : 1.0
// ============================================================================
module lane_merge_arb
    import lane_merge_pkg::*;
#(
    parameter int WIDTH  = 8,
    parameter int NPORTS = 2,
    parameter int MODE   = LM_MODE_FIXED,
    parameter int PTR_W  = 1
) (
    input  logic [NPORTS*WIDTH-1:0] req,
    input  logic [NPORTS*WIDTH-1:0] data,
    input  logic [PTR_W-1:0]        rr_ptr,
    output logic [WIDTH-1:0]        q_next,
    output logic [WIDTH-1:0]        wr_en,
    output logic [NPORTS*WIDTH-1:0] win,
    output logic [WIDTH-1:0]        coll_mask
);

    localparam int IDX_W = (NPORTS * WIDTH > 1) ? $clog2(NPORTS * WIDTH) : 1;

    logic [PTR_W-1:0] start;
    logic [IDX_W-1:0] pos;

    assign start = (MODE == LM_MODE_RR) ? rr_ptr : '0;

    // wr_en[b] doubles as "a winner was already found" while scanning bit b.
    always_comb begin
        q_next    = '0;
        wr_en     = '0;
        win       = '0;
        coll_mask = '0;
        pos       = '0;
        for (int b = 0; b < WIDTH; b++) begin
            for (int k = 0; k < NPORTS; k++) begin
                pos = IDX_W'(lm_rot_port(int'(start), k, NPORTS) * WIDTH + b);
                if (req[pos]) begin
                    if (wr_en[b]) begin
                        coll_mask[b] = 1'b1;
                    end else begin
                        wr_en[b]  = 1'b1;
                        q_next[b] = data[pos];
                        win[pos]  = 1'b1;
                    end
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/lane_merge_reg.sv
`default_nettype none
// ============================================================================
//  Module : lane_merge_reg
//  Brief  : Shared register written by several masked channels with per-bit arbitration.
//  Rev    : 1.0
// ============================================================================
module lane_merge_reg
    import lane_merge_pkg::*;
#(
    parameter int WIDTH  = 8,
    parameter int NPORTS = 2,
    parameter int CNT_W  = 8,
    parameter int MODE   = LM_MODE_FIXED
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [NPORTS-1:0]       wr_valid,
    input  logic [NPORTS*WIDTH-1:0] wr_mask,
    input  logic [NPORTS*WIDTH-1:0] wr_data,
    input  logic                    clr_cnt,
    output logic [WIDTH-1:0]        q,
    output logic [NPORTS-1:0]       grant,
    output logic                    collide,
    output logic [WIDTH-1:0]        collide_mask,
    output logic [CNT_W-1:0]        collide_cnt
);

    localparam int PTR_W = (NPORTS > 1) ? $clog2(NPORTS) : 1;

    logic [NPORTS*WIDTH-1:0] req;
    logic [WIDTH-1:0]        q_next;
    logic [WIDTH-1:0]        wr_en;
    logic [NPORTS*WIDTH-1:0] win;
    logic [WIDTH-1:0]        coll_mask;
    logic [NPORTS-1:0]       grant_next;
    logic                    any_coll;
    logic [PTR_W-1:0]        rr_ptr;

    generate
        for (genvar p = 0; p < NPORTS; p++) begin : g_port
            assign req[p*WIDTH +: WIDTH] = wr_mask[p*WIDTH +: WIDTH] & {WIDTH{wr_valid[p]}};
            assign grant_next[p]         = |win[p*WIDTH +: WIDTH];
        end
    endgenerate

    assign any_coll = |coll_mask;

    lane_merge_arb #(
        .WIDTH  (WIDTH),
        .NPORTS (NPORTS),
        .MODE   (MODE),
        .PTR_W  (PTR_W)
    ) u_arb (
        .req       (req),
        .data      (wr_data),
        .rr_ptr    (rr_ptr),
        .q_next    (q_next),
        .wr_en     (wr_en),
        .win       (win),
        .coll_mask (coll_mask)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q            <= '0;
            grant        <= '0;
            collide      <= 1'b0;
            collide_mask <= '0;
            collide_cnt  <= '0;
            rr_ptr       <= '0;
        end else begin
            q            <= (q & ~wr_en) | (q_next & wr_en);
            grant        <= grant_next;
            collide      <= any_coll;
            collide_mask <= coll_mask;
            // A clear wins over a same-cycle collision; that collision is not counted.
            if (clr_cnt) begin
                collide_cnt <= '0;
            end else if (any_coll && (collide_cnt != {CNT_W{1'b1}})) begin
                collide_cnt <= collide_cnt + 1'b1;
            end
            if ((MODE == LM_MODE_RR) && any_coll) begin
                rr_ptr <= (rr_ptr == PTR_W'(NPORTS - 1)) ? '0 : rr_ptr + 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_lane_merge_reg.sv
`default_nettype none
// ============================================================================
//  Module : tb_lane_merge_reg
//  Brief  : Self-checking bench: fixed, round-robin and narrow-counter instances.
//  Rev    : 1.0
// ============================================================================
module tb_lane_merge_reg;

    localparam int W  = 8;
    localparam int NP = 2;
    localparam int NI = 3;

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic [NP-1:0]  vld = '0;
    logic [W-1:0]   msk [NP];
    logic [W-1:0]   dat [NP];
    logic           clr = 1'b0;
    logic [NP*W-1:0] wmask, wdata;

    assign wmask = {msk[1], msk[0]};
    assign wdata = {dat[1], dat[0]};

    always #5 clk = ~clk;

    logic [W-1:0]  q_f, q_r, q_s, cm_f, cm_r, cm_s;
    logic [NP-1:0] g_f, g_r, g_s;
    logic          c_f, c_r, c_s;
    logic [7:0]    cnt_f, cnt_r;
    logic [1:0]    cnt_s;

    lane_merge_reg #(.WIDTH(W), .NPORTS(NP), .CNT_W(8), .MODE(0)) dut_f (
        .clk(clk), .rst_n(rst_n), .wr_valid(vld), .wr_mask(wmask), .wr_data(wdata),
        .clr_cnt(clr), .q(q_f), .grant(g_f), .collide(c_f), .collide_mask(cm_f),
        .collide_cnt(cnt_f));
    lane_merge_reg #(.WIDTH(W), .NPORTS(NP), .CNT_W(8), .MODE(1)) dut_r (
        .clk(clk), .rst_n(rst_n), .wr_valid(vld), .wr_mask(wmask), .wr_data(wdata),
        .clr_cnt(clr), .q(q_r), .grant(g_r), .collide(c_r), .collide_mask(cm_r),
        .collide_cnt(cnt_r));
    lane_merge_reg #(.WIDTH(W), .NPORTS(NP), .CNT_W(2), .MODE(0)) dut_s (
        .clk(clk), .rst_n(rst_n), .wr_valid(vld), .wr_mask(wmask), .wr_data(wdata),
        .clr_cnt(clr), .q(q_s), .grant(g_s), .collide(c_s), .collide_mask(cm_s),
        .collide_cnt(cnt_s));

    logic [W-1:0]  aq [NI];
    logic [W-1:0]  acm[NI];
    logic [NP-1:0] ag [NI];
    logic          ac [NI];
    logic [7:0]    acnt[NI];
    assign aq[0] = q_f;  assign aq[1] = q_r;  assign aq[2] = q_s;
    assign acm[0] = cm_f; assign acm[1] = cm_r; assign acm[2] = cm_s;
    assign ag[0] = g_f;  assign ag[1] = g_r;  assign ag[2] = g_s;
    assign ac[0] = c_f;  assign ac[1] = c_r;  assign ac[2] = c_s;
    assign acnt[0] = cnt_f; assign acnt[1] = cnt_r; assign acnt[2] = {6'd0, cnt_s};

    // Reference model state, one slot per instance.
    int            mmode[NI] = '{0, 1, 0};
    int            mmax [NI] = '{255, 255, 3};
    logic [W-1:0]  mq   [NI];
    logic [W-1:0]  mcm  [NI];
    logic [NP-1:0] mg   [NI];
    int            mcnt [NI];
    int            mptr [NI];

    int ncmp = 0;
    int nfail = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        ncmp++;
        if (act !== exp) begin
            nfail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < NI; i++) begin
            mq[i] = '0; mcm[i] = '0; mg[i] = '0; mcnt[i] = 0; mptr[i] = 0;
        end
    endtask

    // Each bit goes to the first requester in priority order; two or more requesters collide.
    task automatic model_update();
        for (int i = 0; i < NI; i++) begin
            logic [W-1:0]  cm;
            logic [NP-1:0] g;
            cm = '0;
            g  = '0;
            for (int b = 0; b < W; b++) begin
                int reqs[$];
                int start;
                reqs  = {};
                start = (mmode[i] == 1) ? mptr[i] : 0;
                for (int k = 0; k < NP; k++) begin
                    int p;
                    p = (start + k) % NP;
                    if (vld[p] && msk[p][b]) reqs.push_back(p);
                end
                if (reqs.size() > 0) begin
                    mq[i][b]   = dat[reqs[0]][b];
                    g[reqs[0]] = 1'b1;
                end
                if (reqs.size() > 1) cm[b] = 1'b1;
            end
            mg[i]  = g;
            mcm[i] = cm;
            if (clr) mcnt[i] = 0;
            else if ((cm != 0) && (mcnt[i] < mmax[i])) mcnt[i] = mcnt[i] + 1;
            if ((mmode[i] == 1) && (cm != 0)) mptr[i] = (mptr[i] + 1) % NP;
        end
    endtask

    task automatic check_model();
        for (int i = 0; i < NI; i++) begin
            chk($sformatf("m%0d.q", i),     32'(aq[i]),   32'(mq[i]));
            chk($sformatf("m%0d.grant", i), 32'(ag[i]),   32'(mg[i]));
            chk($sformatf("m%0d.collide", i), 32'(ac[i]), 32'(mcm[i] != 0));
            chk($sformatf("m%0d.cmask", i), 32'(acm[i]),  32'(mcm[i]));
            chk($sformatf("m%0d.cnt", i),   32'(acnt[i]), 32'(mcnt[i]));
        end
    endtask

    // Inputs are set at a falling edge; one rising edge; outputs checked at the next falling edge.
    task automatic step();
        @(posedge clk);
        model_update();
        @(negedge clk);
        check_model();
    endtask

    task automatic drive(input logic [1:0] v, input logic [7:0] m0, input logic [7:0] d0,
                         input logic [7:0] m1, input logic [7:0] d1, input logic c);
        vld = v; msk[0] = m0; dat[0] = d0; msk[1] = m1; dat[1] = d1; clr = c;
    endtask

    typedef struct {
        logic [1:0] v;
        logic [7:0] m0, d0, m1, d1;
        logic       clr;
        logic [7:0] q;
        logic [1:0] g;
        logic       c;
        logic [7:0] cm;
        logic [7:0] cnt;
    } vec_t;

    vec_t tbl[7];

    initial begin
        // Expected values for the fixed-priority instance, starting from reset.
        tbl[0] = '{2'b11, 8'h0F, 8'h05, 8'hF0, 8'hA0, 1'b0, 8'hA5, 2'b11, 1'b0, 8'h00, 8'd0};
        tbl[1] = '{2'b11, 8'h0F, 8'h0F, 8'hF8, 8'h00, 1'b0, 8'h0F, 2'b11, 1'b1, 8'h08, 8'd1};
        tbl[2] = '{2'b00, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 1'b0, 8'h0F, 2'b00, 1'b0, 8'h00, 8'd1};
        tbl[3] = '{2'b01, 8'h00, 8'hFF, 8'h00, 8'h00, 1'b0, 8'h0F, 2'b00, 1'b0, 8'h00, 8'd1};
        tbl[4] = '{2'b10, 8'h00, 8'h00, 8'hFF, 8'h3C, 1'b0, 8'h3C, 2'b10, 1'b0, 8'h00, 8'd1};
        tbl[5] = '{2'b11, 8'hFF, 8'hC3, 8'hFF, 8'h00, 1'b1, 8'hC3, 2'b01, 1'b1, 8'hFF, 8'd0};
        tbl[6] = '{2'b11, 8'h00, 8'hFF, 8'h0F, 8'h05, 1'b0, 8'hC5, 2'b10, 1'b0, 8'h00, 8'd0};

        drive(2'b00, 8'h00, 8'h00, 8'h00, 8'h00, 1'b0);
        model_reset();
        @(negedge clk);
        for (int i = 0; i < NI; i++) begin
            chk($sformatf("rst%0d.q", i), 32'(aq[i]), 32'h0);
            chk($sformatf("rst%0d.cnt", i), 32'(acnt[i]), 32'h0);
        end
        @(negedge clk);
        rst_n = 1'b1;

        for (int t = 0; t < 7; t++) begin
            drive(tbl[t].v, tbl[t].m0, tbl[t].d0, tbl[t].m1, tbl[t].d1, tbl[t].clr);
            step();
            chk($sformatf("tbl%0d.q", t),     32'(q_f),   32'(tbl[t].q));
            chk($sformatf("tbl%0d.grant", t), 32'(g_f),   32'(tbl[t].g));
            chk($sformatf("tbl%0d.collide", t), 32'(c_f), 32'(tbl[t].c));
            chk($sformatf("tbl%0d.cmask", t), 32'(cm_f),  32'(tbl[t].cm));
            chk($sformatf("tbl%0d.cnt", t),   32'(cnt_f), 32'(tbl[t].cnt));
        end

        // Asynchronous reset mid-run with q=A5, cnt=3 on the fixed instance.
        for (int n = 0; n < 3; n++) begin
            drive(2'b11, 8'h0F, 8'h0F, 8'hF8, 8'h00, 1'b0);
            step();
        end
        drive(2'b11, 8'h0F, 8'h05, 8'hF0, 8'hA0, 1'b0);
        step();
        chk("pre_rst.q", 32'(q_f), 32'hA5);
        chk("pre_rst.cnt", 32'(cnt_f), 32'd3);
        #2 rst_n = 1'b0;
        #1;
        for (int i = 0; i < NI; i++) begin
            chk($sformatf("arst%0d.q", i),     32'(aq[i]),   32'h0);
            chk($sformatf("arst%0d.grant", i), 32'(ag[i]),   32'h0);
            chk($sformatf("arst%0d.collide", i), 32'(ac[i]), 32'h0);
            chk($sformatf("arst%0d.cmask", i), 32'(acm[i]),  32'h0);
            chk($sformatf("arst%0d.cnt", i),   32'(acnt[i]), 32'h0);
        end
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;

        // Same overlap five times: round-robin alternation, then counter saturation.
        drive(2'b11, 8'h0F, 8'h0F, 8'hF8, 8'h00, 1'b0);
        step();
        chk("rr1.q", 32'(q_r), 32'h0F);
        step();
        chk("rr2.q", 32'(q_r), 32'h07);
        chk("rr2.cnt", 32'(cnt_r), 32'd2);
        step();
        chk("rr3.q", 32'(q_r), 32'h0F);
        step();
        step();
        chk("sat.cnt_s", 32'(cnt_s), 32'd3);
        chk("sat.cnt_f", 32'(cnt_f), 32'd5);
        clr = 1'b1;
        step();
        chk("clr.cnt_s", 32'(cnt_s), 32'd0);
        chk("clr.collide_s", 32'(c_s), 32'd1);
        chk("clr.cnt_f", 32'(cnt_f), 32'd0);

        // Hold: idle cycles, then a valid port with an empty mask.
        drive(2'b00, 8'hFF, 8'h00, 8'hFF, 8'hFF, 1'b0);
        for (int n = 0; n < 3; n++) begin
            step();
            chk($sformatf("hold%0d.q", n), 32'(q_f), 32'h0F);
            chk($sformatf("hold%0d.grant", n), 32'(g_f), 32'h0);
            chk($sformatf("hold%0d.collide", n), 32'(c_f), 32'h0);
        end
        drive(2'b01, 8'h00, 8'h00, 8'h00, 8'h00, 1'b0);
        step();
        chk("empty.q", 32'(q_f), 32'h0F);
        chk("empty.grant", 32'(g_f), 32'h0);

        for (int n = 0; n < 300; n++) begin
            drive(2'($urandom_range(0, 3)), 8'($urandom), 8'($urandom),
                  8'($urandom), 8'($urandom), ($urandom_range(0, 15) == 0));
            step();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/lane_merge_reg.md
# lane_merge_reg

Parametrised multi-port output register in which several write channels each update a masked subset of bits in one shared register. Per-bit arbitration makes the register a single driver. Overlapping writes resolve deterministically by fixed or round-robin priority, are reported, and are counted. It replaces hand-written designs where separate processes each drive slices of the same register.

## Interface
- `WIDTH`, 8: register width in bits (≥1).
- `NPORTS`, 2: number of write channels (≥2).
- `CNT_W`, 8: width of the saturating collision counter (≥1).
- `MODE`, 0: priority mode; 0 = fixed (lowest port index wins), 1 = round-robin.
- Clock and reset are as decided: one clock; reset is asynchronous and active-low (clk, rst_n).
- `clk`, in, 1: sole clock; all state updates on the rising edge.
- `rst_n`, in, 1: asynchronous, active-low reset.
- `wr_valid`, in, NPORTS: per-port write request.
- `wr_mask`, in, NPORTS*WIDTH: per-port bit enables; port p occupies bits [p*WIDTH +: WIDTH].
- `wr_data`, in, NPORTS*WIDTH: per-port data, packed the same way as `wr_mask`.
- `clr_cnt`, in, 1: synchronous clear of `collide_cnt`.
- `q`, out, WIDTH: merged register value.
- `grant`, out, NPORTS: registered; bit p = port p won at least one bit last cycle.
- `collide`, out, 1: registered one-cycle pulse; some bit had ≥2 requesters last cycle.
- `collide_mask`, out, WIDTH: registered; the bits that had ≥2 requesters last cycle.
- `collide_cnt`, out, CNT_W: saturating count of collision cycles.

## Operation
- **Request.** Port p requests bit b when `wr_valid[p] & wr_mask[p*WIDTH+b]`.
- **Per-bit resolution.** For each bit, the winner is the first requesting port in priority order. `q[b]` then takes that port's data bit. A bit with no requester holds its value.
- **Fixed mode.** Priority order is 0, 1, …, NPORTS-1.
- **Round-robin mode.**
  - Priority order starts at `rr_ptr` and wraps modulo NPORTS.
  - `rr_ptr` advances by 1, with wrap, at the end of every cycle that has a collision.
  - `rr_ptr` holds on collision-free cycles.
  - One pointer is shared by all bits.
- **Collision detection.** A collision on bit b means ≥2 requesters for b. `collide_mask` is the per-bit OR of all collisions. `collide` is the OR-reduction of `collide_mask`.
- **Counter.** `collide_cnt` increments on each collision cycle and saturates at 2^CNT_W-1.
- **Counter clear.** `clr_cnt` forces `collide_cnt` to 0. It takes priority over a simultaneous increment, so that collision is not counted. `collide` and `collide_mask` still report it.
- **No writes.** With no valid port: `q` holds, and `grant`, `collide` and `collide_mask` go to 0.
- **Valid with empty mask.** A valid port whose mask is all zero never wins and never collides.

## Timing
- **Latency.** One cycle. Inputs sampled at edge N appear on `q`, `grant`, `collide` and `collide_mask` after edge N.
- **Reset values.** While `rst_n` is low: `q`, `grant`, `collide`, `collide_mask` and `collide_cnt` are 0, and `rr_ptr` is 0.
- **Reset timing.** Reset takes effect immediately, without waiting for `clk`, including mid-sequence. The first edge after `rst_n` rises samples inputs normally.
- **Back-to-back writes.** Accepted every cycle. There is no backpressure; ports must not assume retry.
- **Output form.** All outputs come directly from flops. There is no combinational input-to-output path.

## Structure
- **Package `lane_merge_pkg`.**
  - Mode constants `LM_MODE_FIXED = 0` and `LM_MODE_RR = 1`.
  - A function returning the rotated port index `(start + k) % NPORTS`.
- **Sub-module `lane_merge_arb`.**
  - Combinational per-bit resolver.
  - Inputs: request matrix, data, `rr_ptr`.
  - Outputs: next `q` bits, the bit write-enable, the winner one-hot per bit, and the collision mask.
- **Top level.** Contains only the flops: `q`, `grant`, `collide*`, the counter and `rr_ptr`.

## Test plan
All scenarios use WIDTH=8, NPORTS=2.

1. **Reset:** assert `rst_n`=0 mid-run with q=0xA5 and collide_cnt=3 → all outputs 0 immediately, before any clock edge.
2. **Disjoint writes:** p0 mask 0x0F data 0x05, p1 mask 0xF0 data 0xA0 → q=0xA5 and grant=2'b11 next cycle; collide=0; cnt unchanged.
3. **Fixed-mode overlap:** p0 mask 0x0F data 0x0F, p1 mask 0xF8 data 0x00 → q=0x0F, collide=1, collide_mask=0x08, cnt=1.
4. **Round-robin overlap:** MODE=1, same stimulus as scenario 3 for two cycles → cycle 1 gives q=0x0F, cycle 2 gives q=0x07 (p1 wins bit 3); cnt=2; `rr_ptr` returns to 0.
5. **Saturation and clear:** CNT_W=2 with 5 consecutive collisions → cnt saturates at 3. Then `clr_cnt` together with a collision → cnt=0 and collide=1.
6. **Hold behaviour:** no valid ports for 3 cycles → q holds its value; grant=0; collide=0. Then p0 valid with mask 0x00 → q holds, grant=0.
